spi_cmd_decoder: RTL and testbench

- Consumes the byte stream produced by the spi slave's bus: read, read_valid, write, plus the frame signal.
- Parses one command per chip-select frame and bridges it to a byte-wide memory port, with auto-incrementing address.
- Supplies the reply bytes that the spi slave shifts out on MISO.
- Sits between the spi module and the cartridge memory arbiter.

---
 rtl/spi_cmd_decoder_if.sv | 31 +++
 rtl/spi_cmd_decoder.sv | 188 ++++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream and memory-port bundle shared by the spi slave, the command
// decoder and the cartridge memory arbiter.
interface spi_cmd_decoder_if #(
    parameter int ADDR_W = 24
);
    logic              frame;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              tx_next;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_req;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic              err;

    // Decoder side.
    modport slave (
        input  frame, rx_data, rx_valid, tx_next, mem_ack, mem_rdata,
        output tx_data, mem_addr, mem_wdata, mem_we, mem_req, busy, err
    );

    // Environment side: spi slave byte stream plus memory arbiter.
    modport master (
        output frame, rx_data, rx_valid, tx_next, mem_ack, mem_rdata,
        input  tx_data, mem_addr, mem_wdata, mem_we, mem_req, busy, err
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: parses one command per chip-select frame (WRITE, READ,
// ID) and bridges it to a byte-wide memory port with auto-incrementing address.
module spi_cmd_decoder #(
    parameter int         ADDR_W = 24,
    parameter logic [7:0] DEV_ID = 8'hFC
) (
    input logic              clk,
    input logic              rst_n,
    spi_cmd_decoder_if.slave bus
);
    localparam logic [7:0]        CMD_WRITE = 8'h53;
    localparam logic [7:0]        CMD_READ  = 8'h52;
    localparam logic [7:0]        CMD_ID    = 8'h9F;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, READ, ID, DRAIN} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_cnt;
    logic              is_read;
    logic [7:0]        hold_data;
    logic              hold_full;
    logic              prefetch_ok;
    logic [7:0]        tx_data;
    logic [7:0]        wdata;
    logic              req;
    logic              we;
    logic              err;
    logic              busy;
    logic              ack;
    logic              abort;

    // Only an ack against our own outstanding request counts.
    assign ack   = req && bus.mem_ack;
    // Chip select dropping wins over anything else happening this cycle.
    assign abort = (state != IDLE) && !bus.frame;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode from frame edges, command byte and address count.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.frame) state_next = CMD;
                CMD: begin
                    if (bus.rx_valid) begin
                        case (bus.rx_data)
                            CMD_WRITE, CMD_READ: state_next = ADDR;
                            CMD_ID:              state_next = ID;
                            default:             state_next = DRAIN;
                        endcase
                    end
                end
                ADDR: begin
                    if (bus.rx_valid && byte_cnt == 2'd2)
                        state_next = is_read ? READ : WRITE;
                end
                default: state_next = state;
            endcase
        end
    end

    // Busy once a command byte has been accepted, until the frame ends.
    always_comb begin
        busy = 1'b0;
        case (state)
            ADDR, WRITE, READ, ID, DRAIN: busy = 1'b1;
            default:                      busy = 1'b0;
        endcase
    end

    // Address, memory request, write holding register and reply byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= '0;
            byte_cnt    <= 2'd0;
            is_read     <= 1'b0;
            hold_data   <= 8'h00;
            hold_full   <= 1'b0;
            prefetch_ok <= 1'b0;
            tx_data     <= 8'hFF;
            wdata       <= 8'h00;
            req         <= 1'b0;
            we          <= 1'b0;
            err         <= 1'b0;
        end else begin
            // An acked request is retired unless a branch below reissues.
            if (ack) req <= 1'b0;
            if (abort) begin
                // Any in-flight request stays up until acked; nothing new starts.
                tx_data     <= 8'hFF;
                hold_full   <= 1'b0;
                prefetch_ok <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.frame) err <= 1'b0;
                    CMD: begin
                        if (bus.rx_valid) begin
                            byte_cnt    <= 2'd0;
                            is_read     <= (bus.rx_data == CMD_READ);
                            hold_full   <= 1'b0;
                            prefetch_ok <= 1'b0;
                            case (bus.rx_data)
                                CMD_WRITE, CMD_READ: ;
                                CMD_ID:  tx_data <= DEV_ID;
                                default: begin
                                    err     <= 1'b1;
                                    tx_data <= 8'hFF;
                                end
                            endcase
                        end
                    end
                    ADDR: begin
                        if (bus.rx_valid) begin
                            addr     <= {addr[ADDR_W-9:0], bus.rx_data};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd2 && is_read) begin
                                req <= 1'b1;
                                we  <= 1'b0;
                            end
                        end
                    end
                    WRITE: begin
                        if (ack) begin
                            addr <= addr + ADDR_ONE;
                            if (hold_full) begin
                                wdata     <= hold_data;
                                req       <= 1'b1;
                                we        <= 1'b1;
                                hold_full <= 1'b0;
                            end
                        end
                        if (bus.rx_valid) begin
                            if (!req || (ack && !hold_full)) begin
                                wdata <= bus.rx_data;
                                req   <= 1'b1;
                                we    <= 1'b1;
                            end else if (!hold_full || ack) begin
                                hold_data <= bus.rx_data;
                                hold_full <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        if (ack) begin
                            tx_data     <= bus.mem_rdata;
                            prefetch_ok <= 1'b1;
                        end
                        if (bus.tx_next) begin
                            if (prefetch_ok || ack) begin
                                prefetch_ok <= 1'b0;
                                addr        <= addr + ADDR_ONE;
                                req         <= 1'b1;
                                we          <= 1'b0;
                            end else begin
                                // Underrun: the late data fills the next slot.
                                tx_data <= 8'hFF;
                                err     <= 1'b1;
                            end
                        end
                    end
                    ID:      if (bus.tx_next) tx_data <= DEV_ID;
                    DRAIN:   tx_data <= 8'hFF;
                    default: ;
                endcase
            end
        end
    end

    assign bus.tx_data   = tx_data;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_we    = we;
    assign bus.mem_req   = req;
    assign bus.busy      = busy;
    assign bus.err       = err;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: directed frames, a latency-programmable memory
// responder, and a transaction model of expected memory accesses.
module tb_spi_cmd_decoder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   ack_lat;
    int   age;
    int   req_cycles;
    int   r0;

    logic [7:0]  mem [logic [23:0]];
    logic [31:0] exp_wr[$];
    logic [23:0] exp_rd[$];

    spi_cmd_decoder_if #(.ADDR_W(24)) bus ();

    spi_cmd_decoder #(.ADDR_W(24), .DEV_ID(8'hFC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
        tick(gap - 1);
    endtask

    task automatic pulse_next(input int gap);
        bus.tx_next = 1'b1;
        tick(1);
        bus.tx_next = 1'b0;
        tick(gap - 1);
    endtask

    task automatic start_frame();
        bus.frame = 1'b1;
        tick(2);
    endtask

    task automatic end_frame();
        bus.frame = 1'b0;
        tick(3);
    endtask

    // Model: a write command to base address a stores byte i at (a + i) mod 2^24.
    task automatic expect_write(input logic [23:0] base, input int i, input logic [7:0] d);
        logic [23:0] a;
        a = base + 24'(i);
        exp_wr.push_back({a, d});
    endtask

    function automatic logic [7:0] rd_mem(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Memory responder: acks ack_lat cycles into each request.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        age = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.mem_ack = 1'b0;
                age = 0;
            end else if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                age = 0;
            end else if (bus.mem_req) begin
                age++;
                if (age >= ack_lat) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                    else            bus.mem_rdata = rd_mem(bus.mem_addr);
                end
            end else begin
                age = 0;
            end
        end
    end

    // Every acked transfer must match the next expected access.
    always @(negedge clk) begin
        if (rst_n && bus.mem_req) req_cycles++;
        if (rst_n && bus.mem_req && bus.mem_ack) begin
            if (bus.mem_we) begin
                if (exp_wr.size() == 0)
                    check("unexpected_write", {bus.mem_addr, bus.mem_wdata}, 32'hFFFF_FFFF);
                else
                    check("mem_write", {bus.mem_addr, bus.mem_wdata}, exp_wr.pop_front());
            end else begin
                if (exp_rd.size() == 0)
                    check("unexpected_read", 32'(bus.mem_addr), 32'hFFFF_FFFF);
                else
                    check("mem_read_addr", 32'(bus.mem_addr), 32'(exp_rd.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_pass = 0; req_cycles = 0; ack_lat = 2;
        rst_n = 1'b0;
        bus.frame = 1'b0; bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_next = 1'b0;
        tick(3);
        check("rst_tx_data", 32'(bus.tx_data), 32'hFF);
        check("rst_req", 32'(bus.mem_req), 32'h0);
        check("rst_we", 32'(bus.mem_we), 32'h0);
        check("rst_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Plain write burst.
        ack_lat = 2;
        expect_write(24'h001000, 0, 8'h11);
        expect_write(24'h001000, 1, 8'h22);
        expect_write(24'h001000, 2, 8'h33);
        expect_write(24'h001000, 3, 8'h44);
        start_frame();
        send(8'h53, 10);
        check("wr_busy", 32'(bus.busy), 32'h1);
        send(8'h00, 10); send(8'h10, 10); send(8'h00, 10);
        send(8'h11, 10); send(8'h22, 10); send(8'h33, 10); send(8'h44, 10);
        check("wr_err", 32'(bus.err), 32'h0);
        check("wr_addr_end", 32'(bus.mem_addr), 32'h001004);
        check("wr_all_done", 32'(exp_wr.size()), 32'h0);
        end_frame();
        check("wr_busy_end", 32'(bus.busy), 32'h0);

        // Read with prefetch.
        ack_lat = 1;
        mem[24'h000200] = 8'hA5;
        mem[24'h000201] = 8'h5A;
        exp_rd.push_back(24'h000200);
        exp_rd.push_back(24'h000201);
        exp_rd.push_back(24'h000202);
        start_frame();
        send(8'h52, 10); send(8'h00, 10); send(8'h02, 10); send(8'h00, 10);
        check("rd_slot0", 32'(bus.tx_data), 32'hA5);
        pulse_next(10);
        check("rd_slot1", 32'(bus.tx_data), 32'h5A);
        pulse_next(10);
        check("rd_addr_end", 32'(bus.mem_addr), 32'h000202);
        check("rd_err", 32'(bus.err), 32'h0);
        end_frame();
        check("rd_tx_idle", 32'(bus.tx_data), 32'hFF);

        // ID command, then unknown command.
        start_frame();
        send(8'h9F, 5);
        check("id_first", 32'(bus.tx_data), 32'hFC);
        pulse_next(5);
        check("id_next1", 32'(bus.tx_data), 32'hFC);
        pulse_next(5);
        check("id_next2", 32'(bus.tx_data), 32'hFC);
        end_frame();
        check("id_tx_idle", 32'(bus.tx_data), 32'hFF);
        r0 = req_cycles;
        start_frame();
        send(8'h7E, 5);
        send(8'h53, 5);
        check("bad_err", 32'(bus.err), 32'h1);
        check("bad_tx", 32'(bus.tx_data), 32'hFF);
        check("bad_busy", 32'(bus.busy), 32'h1);
        end_frame();
        check("bad_no_req", 32'(req_cycles - r0), 32'h0);
        check("bad_err_sticky", 32'(bus.err), 32'h1);
        start_frame();
        check("err_clear_rise", 32'(bus.err), 32'h0);
        end_frame();

        // Write overrun: stalled memory, three bytes back to back.
        ack_lat = 40;
        expect_write(24'h003000, 0, 8'hAA);
        expect_write(24'h003000, 1, 8'hBB);
        start_frame();
        send(8'h53, 10); send(8'h00, 10); send(8'h30, 10); send(8'h00, 10);
        send(8'hAA, 2); send(8'hBB, 2); send(8'hCC, 2);
        check("ovr_err", 32'(bus.err), 32'h1);
        tick(100);
        check("ovr_two_written", 32'(exp_wr.size()), 32'h0);
        check("ovr_third_dropped", 32'(rd_mem(24'h003002)), 32'h00);
        end_frame();

        // Read underrun: first slot requested before data arrives.
        ack_lat = 20;
        mem[24'h000400] = 8'h3C;
        exp_rd.push_back(24'h000400);
        start_frame();
        send(8'h52, 10); send(8'h00, 10); send(8'h04, 10); send(8'h00, 3);
        pulse_next(1);
        check("udr_tx", 32'(bus.tx_data), 32'hFF);
        check("udr_err", 32'(bus.err), 32'h1);
        tick(30);
        check("udr_late_data", 32'(bus.tx_data), 32'h3C);
        end_frame();

        // Address wrap.
        ack_lat = 2;
        expect_write(24'hFFFFFF, 0, 8'h01);
        expect_write(24'hFFFFFF, 1, 8'h02);
        start_frame();
        send(8'h53, 10); send(8'hFF, 10); send(8'hFF, 10); send(8'hFF, 10);
        send(8'h01, 10); send(8'h02, 10);
        check("wrap_hi", 32'(rd_mem(24'hFFFFFF)), 32'h01);
        check("wrap_lo", 32'(rd_mem(24'h000000)), 32'h02);
        end_frame();

        // Frame drop with a write still pending.
        ack_lat = 30;
        expect_write(24'h005000, 0, 8'h77);
        start_frame();
        send(8'h53, 10); send(8'h00, 10); send(8'h50, 10); send(8'h00, 10);
        send(8'h77, 3);
        bus.frame = 1'b0;
        tick(3);
        check("abort_req_held", 32'(bus.mem_req), 32'h1);
        check("abort_busy", 32'(bus.busy), 32'h0);
        tick(40);
        check("abort_req_drop", 32'(bus.mem_req), 32'h0);
        check("abort_written", 32'(rd_mem(24'h005000)), 32'h77);

        // Reset pulse in the middle of a read.
        ack_lat = 1;
        exp_rd.push_back(24'h000200);
        start_frame();
        send(8'h52, 10); send(8'h00, 10); send(8'h02, 10); send(8'h00, 10);
        ack_lat = 50;
        pulse_next(3);
        check("mid_req", 32'(bus.mem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_tx_data", 32'(bus.tx_data), 32'hFF);
        check("mrst_req", 32'(bus.mem_req), 32'h0);
        check("mrst_we", 32'(bus.mem_we), 32'h0);
        check("mrst_addr", 32'(bus.mem_addr), 32'h0);
        check("mrst_wdata", 32'(bus.mem_wdata), 32'h0);
        check("mrst_busy", 32'(bus.busy), 32'h0);
        check("mrst_err", 32'(bus.err), 32'h0);
        bus.frame = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        check("wr_queue_empty", 32'(exp_wr.size()), 32'h0);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
